// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared widths and constant values for the program counter unit.
package pc_unit_pkg;
   localparam int PC_W = 8;
   localparam logic [PC_W-1:0] PC_RESET_L   = 8'h00;
   localparam logic [PC_W-1:0] PC_RESET_H   = 8'h00;
   localparam logic [PC_W-1:0] DB_PRECHARGE = 8'hFF;
endpackage

// File: rtl/pc_half.sv
// pc_half: one 8-bit PC byte with bus/hold select, incrementer and carry chain link.
module pc_half
   import pc_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            ld,
   input  logic            keep,
   input  logic            ci,
   input  logic [PC_W-1:0] d,
   input  logic [PC_W-1:0] rst_val,
   output logic [PC_W-1:0] q,
   output logic            co
);
   logic [PC_W-1:0] s;
   assign s  = ld ? d : q;
   assign co = ci & (s == {PC_W{1'b1}});
   // With no load, no keep and no carry-in the next value equals q, so the write is skipped.
   always_ff @(posedge clk)
      if (rst) q <= rst_val;
      else if (en & (ld | keep | ci)) q <= s + PC_W'(ci);
endmodule

// File: rtl/pc_unit.sv
// pc_unit: 16-bit program counter built from two pc_half bytes, with address and data bus drivers.
module pc_unit
   import pc_unit_pkg::*;
(
   input  logic            PHI0,
   input  logic            RES,
   input  logic            PCL_PCL,
   input  logic            ADL_PCL,
   input  logic            PCH_PCH,
   input  logic            ADH_PCH,
   input  logic            PCL_ADL,
   input  logic            PCH_ADH,
   input  logic            PCL_DB,
   input  logic            PCH_DB,
   input  logic            n_1PC,
   input  logic            n_ready,
   input  logic [PC_W-1:0] ADL_IN,
   input  logic [PC_W-1:0] ADH_IN,
   output logic [PC_W-1:0] ADL_OUT,
   output logic            ADL_OE,
   output logic [PC_W-1:0] ADH_OUT,
   output logic            ADH_OE,
   output logic [PC_W-1:0] DB_OUT,
   output logic            DB_OE,
   output logic [15:0]     PC
);
   logic            inc, en, c, pc_wrap_unused;
   logic [PC_W-1:0] pcl, pch;
   assign en  = ~n_ready;
   assign inc = ~n_1PC & en;

   pc_half u_lo (
      .clk(PHI0), .rst(RES), .en(en), .ld(ADL_PCL), .keep(PCL_PCL), .ci(inc),
      .d(ADL_IN), .rst_val(PC_RESET_L), .q(pcl), .co(c)
   );

   pc_half u_hi (
      .clk(PHI0), .rst(RES), .en(en), .ld(ADH_PCH), .keep(PCH_PCH), .ci(c),
      .d(ADH_IN), .rst_val(PC_RESET_H), .q(pch), .co(pc_wrap_unused)
   );

   assign ADL_OUT = pcl;
   assign ADL_OE  = PCL_ADL;
   assign ADH_OUT = pch;
   assign ADH_OE  = PCH_ADH;
   // Both bytes on the data bus resolve as a wired-AND; an undriven bus stays precharged high.
   assign DB_OUT  = PCL_DB ? (PCH_DB ? (pcl & pch) : pcl) : (PCH_DB ? pch : DB_PRECHARGE);
   assign DB_OE   = PCL_DB | PCH_DB;
   assign PC      = {pch, pcl};
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have ports, in this order:
- PHI0 in 1: single clock; every register updates on the rising edge; one edge = one CPU cycle.
- RES in 1: reset, synchronous, active-high.
REQ-002 SHALL have control inputs, each 1 bit, from the PC control stage:
- PCL_PCL: keep PCL as the low select source.
- ADL_PCL: take the ADL bus as the low select source.
- PCH_PCH: keep PCH as the high select source.
- ADH_PCH: take the ADH bus as the high select source.
- PCL_ADL, PCH_ADH: drive the address buses.
- PCL_DB, PCH_DB: drive the data bus.
REQ-003 SHALL have input n_1PC, 1 bit: active-low increment request.
REQ-004 SHALL have input n_ready, 1 bit: 1 = stall.
REQ-005 SHALL have bus inputs ADL_IN[7:0] and ADH_IN[7:0].
REQ-006 SHALL have outputs:
- ADL_OUT[7:0] and ADL_OE.
- ADH_OUT[7:0] and ADH_OE.
- DB_OUT[7:0] and DB_OE.
- PC[15:0]: debug view, {PCH,PCL}.
REQ-007 SHALL have no parameters; widths are fixed at 8+8.

Function
REQ-010 Low select SHALL be PCLS = ADL_PCL ? ADL_IN : PCL.
- ADL_PCL has priority when both ADL_PCL and PCL_PCL are asserted.
- Neither asserted: PCLS = PCL (hold).
REQ-011 High select SHALL be PCHS = ADH_PCH ? ADH_IN : PCH, with the same priority and hold rules.
REQ-012 Increment SHALL be INC = ~n_1PC & ~n_ready.
REQ-013 Low update SHALL be PCL <= PCLS + INC, modulo 256.
REQ-014 Carry SHALL be C = INC & (PCLS == 8'hFF).
REQ-015 High update SHALL be PCH <= PCHS + C, modulo 256; 16'hFFFF increments to 16'h0000.
REQ-016 Carry SHALL come from PCLS, not from the old PCL, so ADL_PCL with ADL_IN=FF and INC=1 carries into PCH.
REQ-017 While n_ready=1, PCL and PCH SHALL hold and all select/load inputs SHALL be ignored.
- Bus drive outputs still follow their enables.
REQ-018 Address drive SHALL be combinational from the registered values:
- ADL_OUT = PCL and ADL_OE = PCL_ADL.
- ADH_OUT = PCH and ADH_OE = PCH_ADH.
- The drive reflects the value at the start of the cycle; the new value is visible one cycle after the load edge.
REQ-019 Data drive SHALL use DB_OE = PCL_DB | PCH_DB and select DB_OUT as follows:
- PCL_DB only: DB_OUT = PCL.
- PCH_DB only: DB_OUT = PCH.
- Both: DB_OUT = PCL & PCH (NMOS wired-AND).
- Neither: DB_OUT = 8'hFF (precharged).
REQ-020 When an OE is 0, the corresponding *_OUT SHALL still carry its value; OE alone qualifies it.
REQ-021 Load-to-drive latency SHALL be 1 cycle; there is no bypass from ADL_IN/ADH_IN to the outputs.
REQ-022 PC SHALL equal {PCH,PCL} at all times.

Reset
REQ-030 RES=1 at a PHI0 edge SHALL set PCL=8'h00 and PCH=8'h00, overriding stall, load and increment.
REQ-031 During reset SHALL hold: ADL_OE=ADH_OE=DB_OE follow their inputs; DB_OUT follows REQ-019.
REQ-032 The first cycle after RES deasserts SHALL behave normally; a reset asserted mid-increment discards the increment.

Structure
REQ-040 Shared package pc_unit_pkg SHALL hold PC_W=8, PC_RESET_L=8'h00, PC_RESET_H=8'h00 and DB_PRECHARGE=8'hFF.
REQ-041 Sub-module pc_half SHALL contain one 8-bit register with a 2:1 select, the incrementer, carry-in and carry-out; it is instantiated twice.
REQ-042 The low half's carry-out SHALL feed the high half's carry-in; the low half's carry-in is INC.
REQ-043 The top level SHALL contain only the select priority, stall gating, DB merge and output muxing.

Verification
REQ-050 Reset then 3 cycles with n_1PC=0, n_ready=0 and PCL_PCL=PCH_PCH=1 -> PC = 0000, 0001, 0002, 0003.
REQ-051 PC=12FF with INC -> PC=1300; PC=FFFF with INC -> PC=0000.
REQ-052 Jump load -> PC=C0DE next cycle, and ADL_OUT=DE with ADL_OE=1 only in the following cycle.
- ADL_IN=DE, ADH_IN=C0.
- ADL_PCL=ADH_PCH=1, n_1PC=1.
REQ-053 Stall with PC=0040 -> PC stays 0040 for 4 cycles, then reaches 0041 one cycle after n_ready falls.
- n_ready=1 for 4 cycles.
- n_1PC=0.
- ADL_PCL=1, ADL_IN=99.
REQ-054 Data drive with PC=A53C:
- PCL_DB=1 -> DB_OUT=3C.
- PCH_DB=1 -> DB_OUT=A5.
- Both -> DB_OUT=24.
- Neither -> DB_OUT=FF, DB_OE=0.
REQ-055 Reset priority, with PC=1234 and RES=1 in the same cycle as ADL_PCL=1 and INC -> PC=0000; the next cycle with INC -> PC=0001.
